// File: rtl/fir_sym_dual.sv
// Symmetric-coefficient FIR filter, time-multiplexed over N_CH channels: one pre-added tap pair per clock.
// Build option FIR_SYM_DUAL_SAT_EN: saturate out_data at 2^OUT_W-1 instead of wrapping.
`timescale 1ns/1ps
module fir_sym_dual #(
  parameter  int DATA_W    = 8,
  parameter  int COEF_W    = 8,
  parameter  int HALF_TAPS = 11,
  parameter  int N_CH      = 2,
  parameter  int OUT_W     = 20,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int ADDR_W    = (HALF_TAPS > 1) ? $clog2(HALF_TAPS) : 1
) (
  input  logic              CLK_Filter,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [OUT_W-1:0]  out_data
);

  localparam int TAPS   = 2 * HALF_TAPS;
  localparam int TAP_AW = $clog2(TAPS);
  localparam int PROD_W = COEF_W + DATA_W + 1;
  localparam int ACC_W  = DATA_W + 1 + COEF_W + $clog2(HALF_TAPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [COEF_W-1:0] coef_init(input int i);
    case (i)
      0:       return COEF_W'(2);
      1:       return COEF_W'(10);
      2:       return COEF_W'(16);
      3:       return COEF_W'(28);
      4:       return COEF_W'(43);
      5:       return COEF_W'(60);
      6:       return COEF_W'(78);
      7:       return COEF_W'(95);
      8:       return COEF_W'(111);
      9:       return COEF_W'(122);
      10:      return COEF_W'(128);
      default: return '0;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;

  logic [DATA_W-1:0] dline_q [N_CH][TAPS];
  logic [COEF_W-1:0] coef_q  [HALF_TAPS];

  logic              accept;
  logic              coef_wr;
  logic [TAP_AW-1:0] idx_lo, idx_hi;
  logic [DATA_W:0]   pre_add;
  logic [PROD_W-1:0] prod;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_ready && in_valid && (int'(in_ch) < N_CH);
  assign coef_wr  = in_ready && coef_we && (int'(coef_addr) < HALF_TAPS);

  // Tap j pairs with its mirror 2*HALF_TAPS-1-j, so each coefficient is used once per pair.
  assign idx_lo  = TAP_AW'(idx_q);
  assign idx_hi  = TAP_AW'(TAPS - 1) - idx_lo;
  assign pre_add = {1'b0, dline_q[ch_q][idx_lo]} + {1'b0, dline_q[ch_q][idx_hi]};
  assign prod    = PROD_W'(coef_q[idx_q]) * PROD_W'(pre_add);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    ch_d        = ch_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ch_d    = in_ch;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(HALF_TAPS - 1)) begin
          // The result register loads on the edge into DONE so out_valid and out_data coincide.
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_ch_d    = ch_q;
`ifdef FIR_SYM_DUAL_SAT_EN
          if ((acc_d >> OUT_W) != '0) out_data_d = '1;
          else                        out_data_d = OUT_W'(acc_d);
`else
          out_data_d = OUT_W'(acc_d);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      // NOTE: the delay lines and coefficient table are register arrays with a defined reset value, not RAM.
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < TAPS; k++)
          dline_q[c][k] <= '0;
      for (int i = 0; i < HALF_TAPS; i++)
        coef_q[i] <= coef_init(i);
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      if (accept) begin
        for (int k = TAPS - 1; k > 0; k--)
          dline_q[in_ch][k] <= dline_q[in_ch][k-1];
        dline_q[in_ch][0] <= in_data;
      end
      if (coef_wr) coef_q[coef_addr] <= coef_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/fir_sym_dual.md
FIR_SYM_DUAL -- requirements
Module: fir_sym_dual

Interface
REQ-001 Parameter DATA_W, default 8: unsigned input sample width.
REQ-002 Parameter COEF_W, default 8: unsigned coefficient width.
REQ-003 Parameter HALF_TAPS, default 11: symmetric coefficient count; filter order 2*HALF_TAPS-1, delay line 2*HALF_TAPS per channel.
REQ-004 Parameter N_CH, default 2: channel count (ch 0 = RED, ch 1 = IR); CH_W = max(1, clog2(N_CH)).
REQ-005 Parameter OUT_W, default 20: output width.
REQ-006 CLK_Filter  input  1  filter clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  sample present.
REQ-009 in_ch  input  CH_W  channel of sample.
REQ-010 in_data  input  DATA_W  ADC sample.
REQ-011 in_ready  output  1  block can accept sample.
REQ-012 coef_we  input  1  coefficient write strobe.
REQ-013 coef_addr  input  clog2(HALF_TAPS)  coefficient index.
REQ-014 coef_data  input  COEF_W  coefficient value.
REQ-015 out_valid  output  1  one-cycle result strobe.
REQ-016 out_ch  output  CH_W  channel of result.
REQ-017 out_data  output  OUT_W  filtered result.

Function
REQ-018 FSM states IDLE, MAC, DONE; in_ready = 1 only in IDLE.
REQ-019 IDLE: in_valid=1 and in_ch<N_CH -> shift in_data into position 0 of that channel's delay line (others shift by one, oldest dropped), latch channel, clear accumulator, go MAC; other channels' lines untouched.
REQ-020 IDLE: in_valid=1 with in_ch>=N_CH -> sample dropped, stay IDLE, no output.
REQ-021 MAC: one pair per cycle, index j = 0..HALF_TAPS-1: acc += coef[j] * (x[j] + x[2*HALF_TAPS-1-j]); pre-add DATA_W+1 bits, acc width DATA_W+1+COEF_W+clog2(HALF_TAPS), all unsigned; after j=HALF_TAPS-1 go DONE.
REQ-022 DONE: register out_data from acc per REQ-034/035, out_ch = latched channel, out_valid = 1 for exactly this cycle, go IDLE.
REQ-023 Latency: acceptance at cycle 0 -> out_valid at cycle HALF_TAPS+1; max throughput one sample per HALF_TAPS+2 cycles.
REQ-024 out_data/out_ch hold last result until next DONE.
REQ-025 Coefficient write accepted only in IDLE with coef_addr<HALF_TAPS; otherwise ignored; coef_we and accepted sample in same IDLE cycle: write applies first, MAC uses new value.
REQ-026 Write takes effect next cycle; no effect on delay lines.

Reset
REQ-027 rst_n low, any state including mid-MAC: FSM -> IDLE, all delay lines, acc = 0, out_valid = 0, out_ch = 0, out_data = 0; in-flight result discarded.
REQ-028 Coefficients reset to 2,10,16,28,43,60,78,95,111,122,128 for indices 0..10; indices >10 reset to 0.
REQ-029 in_ready = 1 during and immediately after reset.

Configuration
REQ-030 Macro FIR_SYM_DUAL_SAT_EN selects output narrowing.
REQ-031 Defined: acc > 2^OUT_W-1 -> out_data = 2^OUT_W-1; else acc.
REQ-032 Undefined: out_data = acc[OUT_W-1:0] (wrap).
REQ-033 Default parameters: no overflow possible (max 510*693 = 353430 < 2^20); both builds identical.
REQ-034 Saturation/wrap applied only in DONE.
REQ-035 Macro affects no other behaviour or timing.

Verification
REQ-036 Impulse: ch0 sample 1 then 21 zeros -> 22 ch0 results 2,10,16,28,43,60,78,95,111,122,128,128,122,...,10,2; ch1 unaffected.
REQ-037 Constant 100 on ch1 for 22 samples -> 22nd ch1 result 138600, out_ch=1, out_valid at cycle 12 after each acceptance, in_ready low cycles 1..12.
REQ-038 OUT_W=16, constant 255 x22: with FIR_SYM_DUAL_SAT_EN -> 65535; without -> 25750.
REQ-039 rst_n low during MAC cycle 5 -> no out_valid, all outputs 0, next impulse reproduces REQ-036 sequence.
REQ-040 coef_we addr 0 data 50 in IDLE then impulse -> first result 50; coef_we during MAC ignored; in_ch=3 with N_CH=2 -> no output, in_ready stays 1.
